// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first A - B with one registered borrow and a Start/Busy/Done handshake
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sa, r_sb, r_res, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br, r_bout, r_ovf;
  logic             w_d, w_br_next, w_last;
  logic [WIDTH-1:0] w_res_next;
  assign w_d        = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_next  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = r_cnt == CW'(WIDTH-1);
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    o_busy = r_state == SHIFT;
    o_done = r_state == DONE;
    case (r_state)
      IDLE:    w_next = i_start ? SHIFT : IDLE;
      SHIFT:   w_next = w_last ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
  // on the last bit r_sa[0]/r_sb[0] are the captured operand MSBs and w_d is the result MSB
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_sa  <= i_a;
      r_sb  <= i_b;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_res <= w_res_next;
      r_br  <= w_br_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_res_next;
        r_bout <= w_br_next;
        r_ovf  <= (r_sa[0] ^ r_sb[0]) & (w_d ^ r_sa[0]);
      end
    end
  end
  assign o_diff = r_diff;
  assign o_bout = r_bout;
  assign o_ovf  = r_ovf;
endmodule
